wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 196 +++++++++++++++++++
 tb/tb_wb_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue between execute and the register file; load entries wait for memory data.
// Latency: an ALU entry accepted at edge k is retired at edge k+1; a load filled at edge m is retired at edge m+1.
// Backpressure: in_ready = (count < DEPTH) from registered count only; mem_rvalid cannot be stalled.
//
// Ports: clk/rst (async active-high); in_valid/in_ready/in_rd/in_data/in_is_load producer side;
//        mem_rvalid/mem_rdata in-order load returns; rf_wen/rf_waddr/rf_wdata register file write port;
//        raddr_a/busy_a, raddr_b/busy_b hazard query; mem_err sticky unexpected-return flag.
// Optional: define WB_QUEUE_BYPASS_EN to add fwd_a/fwd_b and fwd_data_a/fwd_data_b forwarding outputs.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_data,
    input  logic        in_is_load,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  raddr_a,
    output logic        busy_a,
    input  logic [4:0]  raddr_b,
    output logic        busy_b,
    output logic        mem_err
`ifdef WB_QUEUE_BYPASS_EN
    ,
    output logic        fwd_a,
    output logic        fwd_b,
    output logic [31:0] fwd_data_a,
    output logic [31:0] fwd_data_b
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [DEPTH-1:0] dv_q;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          rf_wen_q, rf_wen_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic          mem_err_q, mem_err_d;

    logic          push, retire, fill;
    logic          fill_hit;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] scan_idx;

    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign retire   = (count_q != '0) && dv_q[head_q];

    // Fill pointer: oldest valid entry still waiting for load data, found by
    // walking from head. Only registered state is scanned, so an entry being
    // pushed this cycle can never be the fill target.
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = head_q;
        scan_idx = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + AW'(k);
            if (!fill_hit && (CW'(k) < count_q) && !dv_q[scan_idx]) begin
                fill_hit = 1'b1;
                fill_idx = scan_idx;
            end
        end
    end

    assign fill = mem_rvalid && fill_hit;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + CW'(push) - CW'(retire);
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        mem_err_d  = mem_err_q || (mem_rvalid && !fill_hit);
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (retire) begin
            head_d     = head_q + AW'(1);
            rf_wen_d   = (rd_q[head_q] != 5'd0);
            rf_waddr_d = rd_q[head_q];
            rf_wdata_d = data_q[head_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            mem_err_q  <= 1'b0;
            dv_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            mem_err_q  <= mem_err_d;
            // tail is never a valid entry when push is allowed, so it cannot
            // collide with fill_idx.
            if (push) begin
                rd_q[tail_q]   <= in_rd;
                data_q[tail_q] <= in_data;
                dv_q[tail_q]   <= !in_is_load;
            end
            if (fill) begin
                data_q[fill_idx] <= mem_rdata;
                dv_q[fill_idx]   <= 1'b1;
            end
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign mem_err  = mem_err_q;

`ifdef WB_QUEUE_BYPASS_EN
    typedef struct packed {
        logic        hit;
        logic        dv;
        logic [31:0] data;
    } match_t;

    // Youngest producer of ra: the output register is older than every queue
    // entry, and entries are walked oldest to youngest so later hits win.
    function automatic match_t youngest_match(input logic [4:0] ra);
        match_t        m;
        logic [AW-1:0] idx;
        m = '0;
        if (rf_wen_q && (rf_waddr_q == ra)) begin
            m.hit  = 1'b1;
            m.dv   = 1'b1;
            m.data = rf_wdata_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + AW'(k);
            if ((CW'(k) < count_q) && (rd_q[idx] == ra)) begin
                m.hit  = 1'b1;
                m.dv   = dv_q[idx];
                m.data = data_q[idx];
            end
        end
        return m;
    endfunction

    match_t match_a, match_b;
    assign match_a    = youngest_match(raddr_a);
    assign match_b    = youngest_match(raddr_b);
    assign busy_a     = (raddr_a != 5'd0) && match_a.hit && !match_a.dv;
    assign busy_b     = (raddr_b != 5'd0) && match_b.hit && !match_b.dv;
    assign fwd_a      = (raddr_a != 5'd0) && match_a.hit && match_a.dv;
    assign fwd_b      = (raddr_b != 5'd0) && match_b.hit && match_b.dv;
    assign fwd_data_a = match_a.data;
    assign fwd_data_b = match_b.data;
`else
    function automatic logic any_match(input logic [4:0] ra);
        logic          h;
        logic [AW-1:0] idx;
        h = rf_wen_q && (rf_waddr_q == ra);
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + AW'(k);
            if ((CW'(k) < count_q) && (rd_q[idx] == ra)) begin
                h = 1'b1;
            end
        end
        return h;
    endfunction

    assign busy_a = (raddr_a != 5'd0) && any_match(raddr_a);
    assign busy_b = (raddr_b != 5'd0) && any_match(raddr_b);
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Testbench for wb_queue: scenario tasks drive stimulus and push expected
// register-file writes into a scoreboard; a negedge monitor pops and compares.
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        in_is_load;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  raddr_a;
    logic        busy_a;
    logic [4:0]  raddr_b;
    logic        busy_b;
    logic        mem_err;
`ifdef WB_QUEUE_BYPASS_EN
    logic        fwd_a, fwd_b;
    logic [31:0] fwd_data_a, fwd_data_b;
`endif

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .in_is_load (in_is_load),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .raddr_a    (raddr_a),
        .busy_a     (busy_a),
        .raddr_b    (raddr_b),
        .busy_b     (busy_b),
        .mem_err    (mem_err)
`ifdef WB_QUEUE_BYPASS_EN
        ,
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .fwd_data_a (fwd_data_a),
        .fwd_data_b (fwd_data_b)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [36:0] sb[$];
    logic [36:0] mon_exp;

    // Every register-file write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (!rst && rf_wen) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rf_write_unexpected: got x%0d=%h, expected no write", rf_waddr, rf_wdata);
            end else begin
                mon_exp = sb.pop_front();
                if ({rf_waddr, rf_wdata} !== mon_exp) begin
                    errors++;
                    $display("FAIL rf_write_order: got x%0d=%h, expected x%0d=%h",
                             rf_waddr, rf_wdata, mon_exp[36:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [4:0] rd, input logic [31:0] data, input logic is_load);
        in_valid   = 1'b1;
        in_rd      = rd;
        in_data    = data;
        in_is_load = is_load;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d writes outstanding, expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_rd = 0; in_data = 0; in_is_load = 0;
        mem_rvalid = 0; mem_rdata = 0; raddr_a = 5'd5; raddr_b = 5'd6;
        step(); step();
        checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (rf_wen !== 1'b0)       begin errors++; $display("FAIL reset_rf_wen: got %b expected 0", rf_wen); end
        checks++; if (rf_waddr !== 5'd0)     begin errors++; $display("FAIL reset_rf_waddr: got %0d expected 0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0)    begin errors++; $display("FAIL reset_rf_wdata: got %h expected 0", rf_wdata); end
        checks++; if ({busy_a, busy_b} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", {busy_a, busy_b}); end
        checks++; if (mem_err !== 1'b0)      begin errors++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu();
        raddr_a = 5'd5;
        sb.push_back({5'd5, 32'h1234});
        push_entry(5'd5, 32'h1234, 1'b0);   // edge k
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL alu_early_wen: got %b expected 0", rf_wen); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL alu_busy_queued: got %b expected 1", busy_a); end
        step();                              // edge k+1
        checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234})
            begin errors++; $display("FAIL alu_write: got wen=%b x%0d=%h expected wen=1 x5=00001234", rf_wen, rf_waddr, rf_wdata); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL alu_busy_outreg: got %b expected 1", busy_a); end
        step();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL alu_wen_drop: got %b expected 0", rf_wen); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL alu_busy_clear: got %b expected 0", busy_a); end
        wait_drain(10);
    endtask

    task automatic test_load_order();
        raddr_a = 5'd10; raddr_b = 5'd11;
        sb.push_back({5'd10, 32'hDEAD});
        push_entry(5'd10, 32'h0, 1'b1);
        sb.push_back({5'd11, 32'd7});
        push_entry(5'd11, 32'd7, 1'b0);
        step(); step();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL load_x11_waits: got wen=%b expected 0", rf_wen); end
        checks++; if ({busy_a, busy_b} !== 2'b11) begin errors++; $display("FAIL load_busy: got %b expected 11", {busy_a, busy_b}); end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        step();                              // fill edge m
        mem_rvalid = 1'b0;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL load_fill_no_retire: got %b expected 0", rf_wen); end
        step();                              // edge m+1
        checks++; if ({rf_wen, rf_waddr} !== {1'b1, 5'd10}) begin errors++; $display("FAIL load_retire_m1: got wen=%b x%0d expected wen=1 x10", rf_wen, rf_waddr); end
        step();
        checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd11, 32'd7}) begin errors++; $display("FAIL load_then_alu: got wen=%b x%0d=%h expected x11=7", rf_wen, rf_waddr, rf_wdata); end
        wait_drain(10);
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL load_mem_err: got %b expected 0", mem_err); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            sb.push_back({5'(i), 32'h100 + 32'(i - 1)});
            push_entry(5'(i), 32'h0, 1'b1);
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h100 + 32'(i);
            step();
            if (i == 0) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_after_fill: got %b expected 0", in_ready); end
            end
            if (i == 1) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_after_retire: got %b expected 1", in_ready); end
            end
        end
        mem_rvalid = 1'b0;
        wait_drain(10);
    endtask

    task automatic test_mem_err();
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        step();
        mem_rvalid = 1'b0;
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL mem_err_set: got %b expected 1", mem_err); end
        step(); step(); step();
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL mem_err_sticky: got %b expected 1", mem_err); end
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL mem_err_no_wen: got %b expected 0", rf_wen); end
    endtask

    task automatic test_rd0();
        do_reset();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rd0_reset_mem_err: got %b expected 0", mem_err); end
        raddr_a = 5'd0;
        in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFFFF; in_is_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            in_valid = 1'b0;
            checks++; if ({busy_a, rf_wen} !== 2'b00) begin errors++; $display("FAIL rd0_cycle%0d: got busy_a=%b wen=%b expected 0 0", i, busy_a, rf_wen); end
        end
    endtask

    task automatic test_reset_mid();
        raddr_b = 5'd8;
        sb.push_back({5'd7, 32'h77});
        push_entry(5'd7, 32'h0, 1'b1);
        push_entry(5'd8, 32'd8, 1'b0);
        push_entry(5'd9, 32'd9, 1'b0);
        push_entry(5'd10, 32'd10, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        step();
        mem_rvalid = 1'b0;
        step();
        checks++; if ({rf_wen, rf_waddr, busy_b} !== {1'b1, 5'd7, 1'b1}) begin errors++; $display("FAIL mid_pre_reset: got wen=%b x%0d busy_b=%b expected 1 x7 1", rf_wen, rf_waddr, busy_b); end
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if ({rf_wen, in_ready, busy_b} !== 3'b010) begin errors++; $display("FAIL mid_reset_async: got wen=%b rdy=%b busy_b=%b expected 0 1 0", rf_wen, in_ready, busy_b); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++; if ({rf_wen, in_ready} !== 2'b01) begin errors++; $display("FAIL mid_after_release: got wen=%b rdy=%b expected 0 1", rf_wen, in_ready); end
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        step();
        mem_rvalid = 1'b0;
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL mid_stale_rvalid: got mem_err=%b expected 1", mem_err); end
        step(); step();
        wait_drain(4);
    endtask

`ifdef WB_QUEUE_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        raddr_a = 5'd3;
        sb.push_back({5'd3, 32'hABC});
        push_entry(5'd3, 32'hABC, 1'b0);
        checks++; if ({fwd_a, fwd_data_a, busy_a} !== {1'b1, 32'hABC, 1'b0}) begin errors++; $display("FAIL bypass_fwd: got fwd=%b data=%h busy=%b expected 1 abc 0", fwd_a, fwd_data_a, busy_a); end
        wait_drain(10);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_order();
        test_full();
        test_mem_err();
        test_rd0();
        test_reset_mid();
`ifdef WB_QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
